// File: rtl/timebase_label_renderer_if.sv
// Pixel-coordinate and label-select bundle for the timebase label renderer.
// The raster source drives coordinates and the requested label; the
// renderer returns the latched label and the registered pixel-on flag.
interface timebase_label_renderer_if;
  logic [11:0] VGA_horzCoord;
  logic [11:0] VGA_vertCoord;
  logic [2:0]  LABEL_SEL;
  logic [2:0]  ACTIVE_SEL;
  logic        CONDITION;

  modport master (
    output VGA_horzCoord, VGA_vertCoord, LABEL_SEL,
    input  ACTIVE_SEL, CONDITION
  );

  modport slave (
    input  VGA_horzCoord, VGA_vertCoord, LABEL_SEL,
    output ACTIVE_SEL, CONDITION
  );
endinterface

// File: rtl/timebase_label_renderer.sv
// Two-stage pipelined renderer for the oscilloscope timebase label.
// Draws one of six strings from a built-in 5x7 glyph ROM at (X0,Y0) with
// 2^SCALE_LOG2 pixel replication. The label is latched only at frame start.
// Optional build macro TIMEBASE_LABEL_BLINK_EN: after a label change the
// text blinks (8 frames on / 8 off) for 63 frames.
module timebase_label_renderer #(
  parameter int unsigned X0         = 245,
  parameter int unsigned Y0         = 940,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned RESET_SEL  = 3
) (
  input  logic                        CLK_VGA,
  input  logic                        RST_N,
  timebase_label_renderer_if.slave    bus
);

  localparam int unsigned D_W        = 13;
  localparam int unsigned BOX_W      = 32'd40 << SCALE_LOG2;
  localparam int unsigned BOX_H      = 32'd7 << SCALE_LOG2;
  localparam int unsigned CHAR_SHIFT = 3 + SCALE_LOG2;

  if (SCALE_LOG2 > 2) begin : g_bad_scale
    $error("timebase_label_renderer: SCALE_LOG2 must be 0..2");
  end

  typedef enum logic [2:0] {
    CH_BLANK = 3'd0,
    CH_0     = 3'd1,
    CH_1     = 3'd2,
    CH_U     = 3'd3,
    CH_M     = 3'd4,
    CH_S     = 3'd5
  } char_t;

  // Character code at position idx of the string selected by sel.
  function automatic char_t char_at(input logic [2:0] sel, input logic [2:0] idx);
    char_t s [5];
    s = '{CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
    case (sel)
      3'd0:    s = '{CH_1, CH_0, CH_U, CH_S, CH_BLANK};
      3'd1:    s = '{CH_1, CH_0, CH_0, CH_U, CH_S};
      3'd2:    s = '{CH_1, CH_M, CH_S, CH_BLANK, CH_BLANK};
      3'd3:    s = '{CH_1, CH_0, CH_M, CH_S, CH_BLANK};
      3'd4:    s = '{CH_1, CH_0, CH_0, CH_M, CH_S};
      3'd5:    s = '{CH_1, CH_S, CH_BLANK, CH_BLANK, CH_BLANK};
      default: s = '{CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK};
    endcase
    char_at = (idx < 3'd5) ? s[idx] : CH_BLANK;
  endfunction

  // 5x7 glyph ROM row; bit 4 is the leftmost column, row 0 the top.
  function automatic logic [4:0] glyph_row(input char_t ch, input logic [2:0] row);
    logic [0:6][4:0] bm;
    case (ch)
      CH_0:    bm = {5'b01110, 5'b10001, 5'b10011, 5'b10101, 5'b11001, 5'b10001, 5'b01110};
      CH_1:    bm = {5'b00100, 5'b01100, 5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b01110};
      CH_U:    bm = {5'b00000, 5'b00000, 5'b10001, 5'b10001, 5'b10001, 5'b10011, 5'b01101};
      CH_M:    bm = {5'b00000, 5'b00000, 5'b11010, 5'b10101, 5'b10101, 5'b10001, 5'b10001};
      CH_S:    bm = {5'b00000, 5'b00000, 5'b01110, 5'b10000, 5'b01110, 5'b00001, 5'b11110};
      default: bm = '0;
    endcase
    glyph_row = (row <= 3'd6) ? bm[row] : 5'b00000;
  endfunction

  logic [2:0]     active_sel_q;
  logic           s1_in_box_q;
  char_t          s1_code_q;
  logic [2:0]     s1_row_q;
  logic [2:0]     s1_col_q;
  logic           cond_q;

  logic [D_W-1:0] dx_c;
  logic [D_W-1:0] dy_c;
  logic           frame_start_c;
  logic [2:0]     sel_eff_c;
  logic           in_box_c;
  char_t          code_c;
  logic [2:0]     row_c;
  logic [2:0]     col_c;
  logic [4:0]     row_bits_c;
  logic           lit_c;
  logic           pix_c;
  logic           blink_off_c;

  // Stage 0: origin-relative offsets, box test and glyph addressing (shifts only).
  always_comb begin
    dx_c          = {1'b0, bus.VGA_horzCoord} - D_W'(X0);
    dy_c          = {1'b0, bus.VGA_vertCoord} - D_W'(Y0);
    frame_start_c = (bus.VGA_horzCoord == 12'd0) && (bus.VGA_vertCoord == 12'd0);
    sel_eff_c     = frame_start_c ? bus.LABEL_SEL : active_sel_q;
    in_box_c      = !dx_c[D_W-1] && !dy_c[D_W-1] &&
                    (dx_c < D_W'(BOX_W)) && (dy_c < D_W'(BOX_H));
    col_c         = 3'(dx_c >> SCALE_LOG2);
    row_c         = 3'(dy_c >> SCALE_LOG2);
    code_c        = char_at(sel_eff_c, 3'(dx_c >> CHAR_SHIFT));
  end

  // Frame latch: the requested label takes effect only at pixel (0,0).
  always_ff @(posedge CLK_VGA or negedge RST_N) begin
    if (!RST_N) begin
      active_sel_q <= 3'(RESET_SEL);
    end else if (frame_start_c) begin
      active_sel_q <= bus.LABEL_SEL;
    end
  end

  // Stage 1: register box flag and glyph address.
  always_ff @(posedge CLK_VGA or negedge RST_N) begin
    if (!RST_N) begin
      s1_in_box_q <= 1'b0;
      s1_code_q   <= CH_BLANK;
      s1_row_q    <= 3'd0;
      s1_col_q    <= 3'd0;
    end else begin
      s1_in_box_q <= in_box_c;
      s1_code_q   <= code_c;
      s1_row_q    <= row_c;
      s1_col_q    <= col_c;
    end
  end

  // ROM lookup; cell columns 5..7 are inter-character spacing.
  always_comb begin
    row_bits_c = glyph_row(s1_code_q, s1_row_q);
    lit_c      = 1'b0;
    if (s1_col_q <= 3'd4) begin
      lit_c = row_bits_c[3'd4 - s1_col_q];
    end
    pix_c = s1_in_box_q & lit_c & ~blink_off_c;
  end

  // Stage 2: registered pixel-on output.
  always_ff @(posedge CLK_VGA or negedge RST_N) begin
    if (!RST_N) begin
      cond_q <= 1'b0;
    end else begin
      cond_q <= pix_c;
    end
  end

`ifdef TIMEBASE_LABEL_BLINK_EN
  logic [5:0] blink_cnt_q;

  // Blink frame counter: reload on a label change, count down per frame to 0.
  always_ff @(posedge CLK_VGA or negedge RST_N) begin
    if (!RST_N) begin
      blink_cnt_q <= 6'd0;
    end else if (frame_start_c) begin
      if (bus.LABEL_SEL != active_sel_q) begin
        blink_cnt_q <= 6'd63;
      end else if (blink_cnt_q != 6'd0) begin
        blink_cnt_q <= blink_cnt_q - 6'd1;
      end
    end
  end

  assign blink_off_c = (blink_cnt_q != 6'd0) && blink_cnt_q[3];
`else
  assign blink_off_c = 1'b0;
`endif

  assign bus.ACTIVE_SEL = active_sel_q;
  assign bus.CONDITION  = cond_q;

endmodule
